// File: rtl/id_issue_scoreboard.sv
// Decode-to-EX issue register with integer/FP destination scoreboards and an
// internal FP-unit occupancy counter that stalls decode on RAW/WAW/structural hazards.
module id_issue_scoreboard #(
   parameter int unsigned  XLEN = 32,
   parameter int unsigned  NREG = 32,
   parameter int unsigned  LATW = 4,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             id_valid,
   output logic             id_ready,
   input  logic [31:0]      id_instr,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [AW-1:0]    id_rs1,
   input  logic [AW-1:0]    id_rs2,
   input  logic [AW-1:0]    id_rd,
   input  logic             id_rs1_en,
   input  logic             id_rs2_en,
   input  logic             id_rd_en,
   input  logic             id_rs1_fp,
   input  logic             id_rs2_fp,
   input  logic             id_rd_fp,
   input  logic             id_fpu_op,
   input  logic [LATW-1:0]  id_lat,

   input  logic             flush,
   input  logic             ex_ready,

   input  logic             wb_en,
   input  logic             wb_fp,
   input  logic [AW-1:0]    wb_rd,

   output logic             ex_valid,
   output logic [31:0]      ex_instr,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [XLEN-1:0]  ex_imm,
   output logic [AW-1:0]    ex_rs1,
   output logic [AW-1:0]    ex_rs2,
   output logic [AW-1:0]    ex_rd,
   output logic             ex_rd_en,
   output logic             ex_rd_fp,

   output logic [NREG-1:0]  busy_int,
   output logic [NREG-1:0]  busy_fp,
   output logic             fpu_busy
);

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [AW-1:0]   rs1;
      logic [AW-1:0]   rs2;
      logic [AW-1:0]   rd;
      logic            rd_en;
      logic            rd_fp;
   } ex_bundle_t;

   logic            ex_valid_q, ex_valid_d;
   ex_bundle_t      ex_q, ex_d, id_bundle_c;
   logic [NREG-1:0] busy_int_q, busy_int_d;
   logic [NREG-1:0] busy_fp_q, busy_fp_d;
   logic [LATW-1:0] fpu_cnt_q, fpu_cnt_d;
   logic            fpu_busy_q, fpu_busy_d;

   logic rs1_busy_c, rs2_busy_c, rd_busy_c, fpu_conflict_c;
   logic hazard_c, ex_free_c, issue_c, kill_c;

   // Hazard detection against the registered scoreboards only (no wb bypass).
   always_comb begin
      rs1_busy_c     = id_rs1_en & (id_rs1_fp ? busy_fp_q[id_rs1] : busy_int_q[id_rs1]);
      rs2_busy_c     = id_rs2_en & (id_rs2_fp ? busy_fp_q[id_rs2] : busy_int_q[id_rs2]);
      rd_busy_c      = id_rd_en  & (id_rd_fp  ? busy_fp_q[id_rd]  : busy_int_q[id_rd]);
      fpu_conflict_c = id_fpu_op & fpu_busy_q;
      hazard_c       = rs1_busy_c | rs2_busy_c | rd_busy_c | fpu_conflict_c;
      ex_free_c      = ~ex_valid_q | ex_ready;
      issue_c        = id_valid & ~hazard_c & ex_free_c & ~flush;
      kill_c         = flush & ex_valid_q & ex_q.rd_en;
   end

   assign id_ready = ~hazard_c & ex_free_c;

   always_comb begin
      id_bundle_c.instr    = id_instr;
      id_bundle_c.pc       = id_pc;
      id_bundle_c.rs1_data = id_rs1_data;
      id_bundle_c.rs2_data = id_rs2_data;
      id_bundle_c.imm      = id_imm;
      id_bundle_c.rs1      = id_rs1;
      id_bundle_c.rs2      = id_rs2;
      id_bundle_c.rd       = id_rd;
      id_bundle_c.rd_en    = id_rd_en;
      id_bundle_c.rd_fp    = id_rd_fp;
   end

   // EX register: flush beats issue beats drain; otherwise hold.
   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_d       = ex_q;
      if (flush) begin
         ex_valid_d = 1'b0;
      end else if (issue_c) begin
         ex_valid_d = 1'b1;
         ex_d       = id_bundle_c;
      end else if (ex_ready) begin
         ex_valid_d = 1'b0;
      end
   end

   // Scoreboards: clears first so a same-cycle set wins; x0 is never tracked.
   always_comb begin
      busy_int_d = busy_int_q;
      busy_fp_d  = busy_fp_q;
      if (wb_en) begin
         if (wb_fp) busy_fp_d[wb_rd]  = 1'b0;
         else       busy_int_d[wb_rd] = 1'b0;
      end
      if (kill_c) begin
         if (ex_q.rd_fp) busy_fp_d[ex_q.rd]  = 1'b0;
         else            busy_int_d[ex_q.rd] = 1'b0;
      end
      if (issue_c && id_rd_en) begin
         if (id_rd_fp)              busy_fp_d[id_rd]  = 1'b1;
         else if (id_rd != '0)      busy_int_d[id_rd] = 1'b1;
      end
      busy_int_d[0] = 1'b0;
   end

   // FP occupancy counter; a flush does not cancel work already in the unit.
   always_comb begin
      fpu_cnt_d = fpu_cnt_q;
      if (issue_c && id_fpu_op && (id_lat != '0)) begin
         fpu_cnt_d = id_lat;
      end else if (fpu_cnt_q != '0) begin
         fpu_cnt_d = fpu_cnt_q - LATW'(1);
      end
      fpu_busy_d = (fpu_cnt_d != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
         busy_int_q <= '0;
         busy_fp_q  <= '0;
         fpu_cnt_q  <= '0;
         fpu_busy_q <= 1'b0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_q       <= ex_d;
         busy_int_q <= busy_int_d;
         busy_fp_q  <= busy_fp_d;
         fpu_cnt_q  <= fpu_cnt_d;
         fpu_busy_q <= fpu_busy_d;
      end
   end

   assign ex_valid    = ex_valid_q;
   assign ex_instr    = ex_q.instr;
   assign ex_pc       = ex_q.pc;
   assign ex_rs1_data = ex_q.rs1_data;
   assign ex_rs2_data = ex_q.rs2_data;
   assign ex_imm      = ex_q.imm;
   assign ex_rs1      = ex_q.rs1;
   assign ex_rs2      = ex_q.rs2;
   assign ex_rd       = ex_q.rd;
   assign ex_rd_en    = ex_q.rd_en;
   assign ex_rd_fp    = ex_q.rd_fp;
   assign busy_int    = busy_int_q;
   assign busy_fp     = busy_fp_q;
   assign fpu_busy    = fpu_busy_q;

endmodule
